// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder stage.
// State encoding is also used by bench monitors.
package serial_adder_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADD  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_ADD  = S_ADD,
        ST_DONE = S_DONE
    } state_t;

endpackage

// File: rtl/half_adder.sv
// Single-bit half adder cell.
module half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b;
    assign carry = a & b;

endmodule

// File: rtl/serial_adder_full_adder.sv
// Full adder built from two half_adder cells and an OR of their carries.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic s0;
    logic c0;
    logic c1;

    half_adder u_ha0 (
        .a     (a),
        .b     (b),
        .sum   (s0),
        .carry (c0)
    );

    half_adder u_ha1 (
        .a     (s0),
        .b     (cin),
        .sum   (sum),
        .carry (c1)
    );

    assign cout = c0 | c1;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: one WIDTH-bit addition over WIDTH cycles.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] s_sh;
    logic [WIDTH-1:0] s_next;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s;
    logic             fa_c;
    logic             last;

    full_adder u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .sum  (fa_s),
        .cout (fa_c)
    );

    assign last = (cnt == CW'(WIDTH - 1));

    // Works for WIDTH=1, where the shift leaves only the new bit.
    always_comb begin
        s_next = s_sh >> 1;
        s_next[WIDTH-1] = fa_s;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            s_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        s_sh  <= '0;
                        carry <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= ST_ADD;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_ADD: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    s_sh  <= s_next;
                    carry <= fa_c;
                    cnt   <= cnt + CW'(1);
                    if (last) begin
                        sum   <= s_next;
                        cout  <= fa_c;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder at WIDTH 8, 4 and 1.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst8 = 1'b1;
    logic       rsto = 1'b1;

    logic       st8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;

    logic       st4 = 1'b0;
    logic [3:0] a4 = '0;
    logic [3:0] b4 = '0;
    logic       busy4, done4, cout4;
    logic [3:0] sum4;

    logic       st1 = 1'b0;
    logic [0:0] a1 = '0;
    logic [0:0] b1 = '0;
    logic       busy1, done1, cout1;
    logic [0:0] sum1;

    int nchk = 0;
    int nerr = 0;

    logic [31:0] q8[$];
    logic [31:0] q4[$];
    logic [31:0] q1[$];

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst8), .start(st8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rsto), .start(st4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rsto), .start(st1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [31:0] e;
        if (done8) begin
            if (q8.size() == 0) check("done8_unexp", 1, 0);
            else begin
                e = q8.pop_front();
                check("res8", {23'b0, cout8, sum8}, e);
            end
        end
        if (done4) begin
            if (q4.size() == 0) check("done4_unexp", 1, 0);
            else begin
                e = q4.pop_front();
                check("res4", {27'b0, cout4, sum4}, e);
            end
        end
        if (done1) begin
            if (q1.size() == 0) check("done1_unexp", 1, 0);
            else begin
                e = q1.pop_front();
                check("res1", {30'b0, cout1, sum1}, e);
            end
        end
    end

    task automatic wait_done8(output int nb, output bit got);
        nb = 0;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (done8) got = 1;
            else begin
                if (busy8) nb++;
                @(negedge clk);
            end
        end
    endtask

    task automatic op8(input logic [7:0] x, input logic [7:0] y);
        int nb;
        bit got;
        @(negedge clk);
        st8 = 1'b1; a8 = x; b8 = y;
        q8.push_back(32'(x) + 32'(y));
        @(negedge clk);
        st8 = 1'b0;
        wait_done8(nb, got);
        check("done8_seen", 32'(got), 1);
        check("busy8_len", nb, 8);
    endtask

    task automatic op4(input logic [3:0] x, input logic [3:0] y);
        bit got;
        @(negedge clk);
        st4 = 1'b1; a4 = x; b4 = y;
        q4.push_back(32'(x) + 32'(y));
        @(negedge clk);
        st4 = 1'b0;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            if (done4) got = 1;
            else @(negedge clk);
        end
        check("done4_seen", 32'(got), 1);
    endtask

    initial begin
        int nb;
        bit got;
        int nd;
        int pos[3];

        repeat (2) @(negedge clk);
        rst8 = 1'b0;
        rsto = 1'b0;
        check("rst_busy", 32'(busy8), 0);
        check("rst_done", 32'(done8), 0);
        check("rst_sum", 32'(sum8), 0);
        check("rst_cout", 32'(cout8), 0);

        op8(8'h00, 8'h00);
        op8(8'hFF, 8'h01);
        op8(8'hA5, 8'h5A);

        // Start during ADD must be ignored.
        @(negedge clk);
        st8 = 1'b1; a8 = 8'h3C; b8 = 8'h42;
        q8.push_back(32'h7E);
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'hFF;
        repeat (3) @(negedge clk);
        st8 = 1'b0;
        wait_done8(nb, got);
        check("ign_done", 32'(got), 1);
        check("ign_sum_hold", 32'(sum8), 32'h7E);

        // Reset during the 4th ADD cycle aborts the operation.
        @(negedge clk);
        st8 = 1'b1; a8 = 8'h01; b8 = 8'h02;
        @(negedge clk);
        st8 = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_busy_pre", 32'(busy8), 1);
        rst8 = 1'b1;
        @(negedge clk);
        rst8 = 1'b0;
        check("abort_busy", 32'(busy8), 0);
        check("abort_done", 32'(done8), 0);
        check("abort_sum", 32'(sum8), 0);
        check("abort_cout", 32'(cout8), 0);
        nd = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done8) nd++;
        end
        check("abort_nodone", nd, 0);
        op8(8'h10, 8'h20);

        // Start held high: back-to-back with no IDLE gap.
        @(negedge clk);
        st8 = 1'b1; a8 = 8'h80; b8 = 8'h80;
        repeat (3) q8.push_back(32'h100);
        nd = 0;
        for (int i = 0; i < 40 && nd < 3; i++) begin
            @(negedge clk);
            check("held_active", 32'(busy8 | done8), 1);
            if (done8) begin
                pos[nd] = i;
                nd++;
                if (nd == 3) st8 = 1'b0;
            end
        end
        check("held_ndone", nd, 3);
        check("held_pos0", pos[0], 8);
        check("held_pos1", pos[1], 17);
        check("held_pos2", pos[2], 26);
        repeat (2) @(negedge clk);
        check("held_idle", 32'(busy8 | done8), 0);

        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
                op4(4'(x), 4'(y));

        @(negedge clk);
        st1 = 1'b1; a1 = 1'b1; b1 = 1'b1;
        q1.push_back(32'd2);
        @(negedge clk);
        st1 = 1'b0;
        check("w1_busy", 32'(busy1), 1);
        check("w1_done_early", 32'(done1), 0);
        @(negedge clk);
        check("w1_done", 32'(done1), 1);
        check("w1_busy_off", 32'(busy1), 0);

        repeat (3) @(negedge clk);
        check("q8_empty", q8.size(), 0);
        check("q4_empty", q4.size(), 0);
        check("q1_empty", q1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
